spi_config_writer: RTL and testbench
====================================

Name: spi_config_writer

Overview:
- Host-facing SPI-mode-0 slave that decodes 32-bit register-write frames into the per-operator config write bus.
- Drives the envelope-config and note-on-config write enables, write address and write data consumed by the envelope attenuator stage (and other config-bearing stages).
- Sole producer of config writes in the synth core; all writes are single-cycle strobes in the i_Clock domain.

Parameters:
- NUM_VOICE_OPERATORS, 32, number of valid voice-operator IDs; IDs at or above this value are rejected.
- VOICE_OP_WIDTH, 8, width of VoiceOperatorID_t; the address low byte is truncated to this width.

Ports:
- i_Clock  in  1  core clock; must run at 8x SCK or faster.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_SpiSck  in  1  SPI clock, asynchronous to i_Clock.
- i_SpiCs_n  in  1  SPI chip select, active low, asynchronous.
- i_SpiMosi  in  1  SPI data in, MSB first.
- o_SpiMiso  out  1  status word out, MSB first.
- o_EnvelopeConfigWriteEnable  out  5  one-hot write strobe per envelope field.
- o_NoteOnConfigWriteEnable  out  2  [0] writes note-on bits 15:0, [1] writes bits 31:16.
- o_ConfigWriteAddr  out  VOICE_OP_WIDTH  voice operator ID.
- o_ConfigWriteData  out  16  write payload.
- o_Error  out  3  sticky error flags: [0] aborted frame, [1] bad select, [2] bad voice operator ID.

Behaviour:
- Reset: every output, shift register, bit counter, frame counter, error flag and synchronizer flop is 0, except o_SpiMiso = 0 and the CS synchronizer, which resets to 1 (deselected).
- Synchronization:
  - 2-flop synchronizers on SCK, CS_n and MOSI.
  - A third SCK flop provides rise and fall pulses.
  - All internal logic runs on i_Clock.
- CS_n high (synchronized): bit counter = 0; the shift register is held.
- Shifting: on a rise pulse with CS_n low, shift MOSI into the 32-bit shift register LSB-side and increment the 5-bit bit counter.
- Frame completion: on the rise pulse that completes bit 32, the counter wraps to 0. Multiple frames per CS assertion are legal, and each frame is decoded independently.
- Frame format: bits[31:16] = address, bits[15:0] = data.
  - Address [15:8] = select.
  - Address [7:0] = voice operator ID.
- Select decode:
  - 0x00..0x04: envelope config fields, in order AttackLevel, SustainLevel, AttackRate, DecayRate, ReleaseRate. Drives o_EnvelopeConfigWriteEnable bit [select].
  - 0x10: note-on low half (o_NoteOnConfigWriteEnable[0]). The voice operator ID is ignored.
  - 0x11: note-on high half (o_NoteOnConfigWriteEnable[1]). The voice operator ID is ignored.
  - 0x1F: clear o_Error and emit no strobe.
  - Any other select: no strobe, set o_Error[1].
- Bad ID: an envelope select with voice operator ID >= NUM_VOICE_OPERATORS emits no strobe and sets o_Error[2].
- Write timing:
  - Completing rise pulse in cycle N gives exactly one strobe bit high in cycle N+1, for one cycle only.
  - Addr and data are valid in N+1 and hold their values until the next accepted write.
  - At most one of the 7 enable bits is high in any cycle.
- Abort: CS_n rising while bit counter != 0 discards the partial frame, emits no strobe, and sets o_Error[0].
- Frame counter: 8 bits, increments on every completed frame (including rejected frames), wraps from 255 to 0.
- MISO:
  - When CS_n falls, and on each frame wrap, load the status word {frame counter[7:0], 5'b0, o_Error}.
  - Present the MSB immediately; shift on each fall pulse.
  - Drive 0 during bits 16..31 of the frame and while CS_n is high.
- Simultaneous events: a clear (0x1F) frame and an error-setting condition in the same cycle resolve to clear-wins. A set in a later cycle is retained.
- Reset mid-frame: the partial frame is lost, with no strobe and no error flag.

Decomposition:
- synth.svh additions:
  - CONFIG_SELECT_* constants (0x00..0x04, 0x10, 0x11, 0x1F).
  - EnvelopeConfigField_t enum (5 entries, matching write-enable bit order).
  - ConfigError_t bit indices.
- One sub-module, spi_sync_edge: 2-flop synchronizer plus edge detector with parameterized reset value. Instantiated for SCK (rise/fall), CS_n (rise/fall) and MOSI (level only).

Test Plan:
- Envelope write: frame 0x0203_1234 (AttackRate, ID 3) -> o_EnvelopeConfigWriteEnable = 5'b00100 for one cycle; addr = 3, data = 0x1234; o_Error = 0.
- Note-on write: frame 0x1100_8001 -> o_NoteOnConfigWriteEnable = 2'b10, data = 0x8001, one cycle. Then frame 0x1000_0001 -> 2'b01.
- Back-to-back streaming: two frames (0x0000_3FFF, 0x0101_0800) in one CS assertion -> two single-cycle strobes (bit 0 then bit 1) with matching addr/data; frame counter = 2.
- Abort: CS_n raised after 20 bits -> no strobe, o_Error = 3'b001. Then frame 0x1F00_0000 -> o_Error = 0.
- Rejects:
  - Frame 0x0420_0000 (ID 32) -> no strobe, o_Error[2] = 1.
  - Frame 0x0500_0000 -> no strobe, o_Error[1] = 1.
  - Next frame's MISO first 16 bits = 0x0206 (count 2, errors 3'b110).
- Async reset asserted mid-frame (bit 10) -> all outputs 0 immediately. After release, a clean frame 0x0300_0ABC yields a DecayRate strobe with data 0x0ABC.

Source files
------------

// File: rtl/spi_config_writer_pkg.sv
// Shared constants and types for the SPI config writer: select codes,
// envelope field ordering and sticky error bit positions.
package spi_config_writer_pkg;

  localparam int DEFAULT_NUM_VOICE_OPERATORS = 32;
  localparam int DEFAULT_VOICE_OP_WIDTH      = 8;

  localparam logic [7:0] CONFIG_SELECT_ATTACK_LEVEL  = 8'h00;
  localparam logic [7:0] CONFIG_SELECT_SUSTAIN_LEVEL = 8'h01;
  localparam logic [7:0] CONFIG_SELECT_ATTACK_RATE   = 8'h02;
  localparam logic [7:0] CONFIG_SELECT_DECAY_RATE    = 8'h03;
  localparam logic [7:0] CONFIG_SELECT_RELEASE_RATE  = 8'h04;
  localparam logic [7:0] CONFIG_SELECT_NOTE_ON_LO    = 8'h10;
  localparam logic [7:0] CONFIG_SELECT_NOTE_ON_HI    = 8'h11;
  localparam logic [7:0] CONFIG_SELECT_CLEAR_ERROR   = 8'h1F;

  // Enum order matches the envelope write-enable bit order.
  typedef enum logic [2:0] {
    ENV_ATTACK_LEVEL  = 3'd0,
    ENV_SUSTAIN_LEVEL = 3'd1,
    ENV_ATTACK_RATE   = 3'd2,
    ENV_DECAY_RATE    = 3'd3,
    ENV_RELEASE_RATE  = 3'd4
  } envelope_config_field_t;

  localparam int CONFIG_ERROR_ABORT        = 0;
  localparam int CONFIG_ERROR_BAD_SELECT   = 1;
  localparam int CONFIG_ERROR_BAD_VOICE_OP = 2;

endpackage

// File: rtl/spi_config_writer_sync_edge.sv
// Two-flop synchronizer with a third flop for single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_config_writer.sv
// SPI mode-0 slave that decodes 32-bit {select, voice_id, data} frames into
// single-cycle config write strobes and returns a status word on MISO.
module spi_config_writer
  import spi_config_writer_pkg::*;
#(
  parameter int NUM_VOICE_OPERATORS = DEFAULT_NUM_VOICE_OPERATORS,
  parameter int VOICE_OP_WIDTH      = DEFAULT_VOICE_OP_WIDTH
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic                      i_SpiSck,
  input  logic                      i_SpiCs_n,
  input  logic                      i_SpiMosi,
  output logic                      o_SpiMiso,
  output logic [4:0]                o_EnvelopeConfigWriteEnable,
  output logic [1:0]                o_NoteOnConfigWriteEnable,
  output logic [VOICE_OP_WIDTH-1:0] o_ConfigWriteAddr,
  output logic [15:0]               o_ConfigWriteData,
  output logic [2:0]                o_Error
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_n, cs_rise, cs_fall;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk_i  (i_Clock),
    .rst_n_i(i_Reset_n),
    .d_i    (i_SpiSck),
    .level_o(sck_level_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_i  (i_Clock),
    .rst_n_i(i_Reset_n),
    .d_i    (i_SpiCs_n),
    .level_o(cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk_i  (i_Clock),
    .rst_n_i(i_Reset_n),
    .d_i    (i_SpiMosi),
    .level_o(mosi),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  logic [31:0]               shift_q, shift_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                frame_cnt_q, frame_cnt_d;
  logic [2:0]                err_q, err_d;
  logic [4:0]                env_en_q, env_en_d;
  logic [1:0]                note_en_q, note_en_d;
  logic [VOICE_OP_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]               data_q, data_d;
  logic [15:0]               miso_sr_q, miso_sr_d;
  logic                      miso_q, miso_d;

  logic [31:0]               frame;
  logic [7:0]                sel;
  logic [VOICE_OP_WIDTH-1:0] voice_id;
  logic                      frame_done;
  logic [2:0]                err_set;
  logic                      err_clr;

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    env_en_d    = '0;
    note_en_d   = '0;
    addr_d      = addr_q;
    data_d      = data_q;
    miso_sr_d   = miso_sr_q;
    err_set     = '0;
    err_clr     = 1'b0;
    frame_done  = 1'b0;
    frame       = {shift_q[30:0], mosi};
    sel         = frame[31:24];
    voice_id    = frame[16 +: VOICE_OP_WIDTH];

    if (cs_n) begin
      bit_cnt_d = '0;
      if (cs_rise && (bit_cnt_q != 5'd0)) begin
        err_set[CONFIG_ERROR_ABORT] = 1'b1;
      end
    end else if (sck_rise) begin
      shift_d   = frame;
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (bit_cnt_q == 5'd31) begin
        frame_done  = 1'b1;
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (sel <= CONFIG_SELECT_RELEASE_RATE) begin
          if (int'(voice_id) >= NUM_VOICE_OPERATORS) begin
            err_set[CONFIG_ERROR_BAD_VOICE_OP] = 1'b1;
          end else begin
            env_en_d[sel[2:0]] = 1'b1;
            addr_d             = voice_id;
            data_d             = frame[15:0];
          end
        end else if (sel == CONFIG_SELECT_NOTE_ON_LO) begin
          note_en_d[0] = 1'b1;
          addr_d       = voice_id;
          data_d       = frame[15:0];
        end else if (sel == CONFIG_SELECT_NOTE_ON_HI) begin
          note_en_d[1] = 1'b1;
          addr_d       = voice_id;
          data_d       = frame[15:0];
        end else if (sel == CONFIG_SELECT_CLEAR_ERROR) begin
          err_clr = 1'b1;
        end else begin
          err_set[CONFIG_ERROR_BAD_SELECT] = 1'b1;
        end
      end
    end else if (sck_fall && (bit_cnt_q != 5'd0)) begin
      // The fall that follows a frame-completing rise sees count 0 and must
      // not disturb the freshly loaded status word.
      miso_sr_d = {miso_sr_q[14:0], 1'b0};
    end

    err_d = err_clr ? 3'b000 : (err_q | err_set);

    // The status word reflects the frame that just completed.
    if (cs_fall || frame_done) begin
      miso_sr_d = {frame_cnt_d, 5'b00000, err_d};
    end

    miso_d = (!cs_n && !bit_cnt_d[4]) ? miso_sr_d[15] : 1'b0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      err_q       <= '0;
      env_en_q    <= '0;
      note_en_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      miso_sr_q   <= '0;
      miso_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      env_en_q    <= env_en_d;
      note_en_q   <= note_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      miso_sr_q   <= miso_sr_d;
      miso_q      <= miso_d;
    end
  end

  assign o_SpiMiso                   = miso_q;
  assign o_EnvelopeConfigWriteEnable = env_en_q;
  assign o_NoteOnConfigWriteEnable   = note_en_q;
  assign o_ConfigWriteAddr           = addr_q;
  assign o_ConfigWriteData           = data_q;
  assign o_Error                     = err_q;

endmodule

// File: tb/tb_spi_config_writer.sv
// Bench for spi_config_writer: bit-banged SPI frames, strobe scoreboard,
// error flag and MISO status word checks.
module tb_spi_config_writer;

  localparam int W    = 31;
  localparam int HALF = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck   = 1'b0;
  logic        cs_n  = 1'b1;
  logic        mosi  = 1'b0;
  logic        miso;
  logic [4:0]  env_en;
  logic [1:0]  note_en;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [2:0]  err;

  logic [W-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  spi_config_writer dut (
    .i_Clock                    (clk),
    .i_Reset_n                  (rst_n),
    .i_SpiSck                   (sck),
    .i_SpiCs_n                  (cs_n),
    .i_SpiMosi                  (mosi),
    .o_SpiMiso                  (miso),
    .o_EnvelopeConfigWriteEnable(env_en),
    .o_NoteOnConfigWriteEnable  (note_en),
    .o_ConfigWriteAddr          (addr),
    .o_ConfigWriteData          (data),
    .o_Error                    (err)
  );

  // Scoreboard: every strobe cycle pops one expected {env, note, addr, data}.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if ((env_en != 5'b0) || (note_en != 2'b0)) begin
      total_cnt++;
      if ($countones({env_en, note_en}) != 1)
        $display("FAIL strobe_onehot: got env=%b note=%b want exactly one bit", env_en, note_en);
      else
        pass_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: got env=%b note=%b addr=%h data=%h want none",
                 env_en, note_en, addr, data);
      end else begin
        exp_v = exp_q.pop_front();
        if ({env_en, note_en, addr, data} !== exp_v)
          $display("FAIL strobe: got %h want %h", {env_en, note_en, addr, data}, exp_v);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tick(3);
    @(negedge clk) rst_n = 1'b1;
    tick(3);
  endtask

  task automatic cs_assert();
    @(negedge clk) cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_release();
    tick(HALF);
    @(negedge clk) cs_n = 1'b1;
    tick(HALF);
  endtask

  task automatic push_exp(input logic [4:0] e, input logic [1:0] n,
                          input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({e, n, a, d});
  endtask

  // Sends the top n bits of w MSB first; MISO is sampled just before each rise.
  task automatic send_bits(input logic [31:0] w, input int n, output logic [31:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk) mosi = w[31-i];
      tick(HALF);
      @(negedge clk);
      miso_w = {miso_w[30:0], miso};
      sck = 1'b1;
      tick(HALF);
      @(negedge clk) sck = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic check_drained(input string name);
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_missing_strobes: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({env_en, note_en, addr, data, err, miso} !== 34'h0)
      $display("FAIL reset_outputs: got %h want 0", {env_en, note_en, addr, data, err, miso});
    else
      pass_cnt++;
  endtask

  task automatic test_envelope();
    logic [31:0] m;
    do_reset();
    cs_assert();
    push_exp(5'b00100, 2'b00, 8'd3, 16'h1234);
    send_bits(32'h0203_1234, 32, m);
    total_cnt++;
    if (m !== 32'h0000_0000) $display("FAIL env_miso: got %h want 00000000", m);
    else pass_cnt++;
    total_cnt++;
    if (err !== 3'b000) $display("FAIL env_error: got %b want 000", err);
    else pass_cnt++;
    tick(20);
    total_cnt++;
    if ({addr, data} !== {8'd3, 16'h1234})
      $display("FAIL env_hold: got %h %h want 03 1234", addr, data);
    else
      pass_cnt++;
    push_exp(5'b00001, 2'b00, 8'h1F, 16'h0005);
    send_bits(32'h001F_0005, 32, m);
    total_cnt++;
    if (err !== 3'b000) $display("FAIL env_id31_error: got %b want 000", err);
    else pass_cnt++;
    cs_release();
    check_drained("envelope");
  endtask

  task automatic test_note_on();
    logic [31:0] m;
    do_reset();
    cs_assert();
    push_exp(5'b00000, 2'b10, 8'h00, 16'h8001);
    send_bits(32'h1100_8001, 32, m);
    push_exp(5'b00000, 2'b01, 8'h00, 16'h0001);
    send_bits(32'h1000_0001, 32, m);
    cs_release();
    total_cnt++;
    if (err !== 3'b000) $display("FAIL note_error: got %b want 000", err);
    else pass_cnt++;
    check_drained("note_on");
  endtask

  task automatic test_back_to_back();
    logic [31:0] m;
    do_reset();
    cs_assert();
    push_exp(5'b00001, 2'b00, 8'h00, 16'h3FFF);
    send_bits(32'h0000_3FFF, 32, m);
    push_exp(5'b00010, 2'b00, 8'h01, 16'h0800);
    send_bits(32'h0101_0800, 32, m);
    total_cnt++;
    if (m !== 32'h0100_0000) $display("FAIL b2b_miso_frame2: got %h want 01000000", m);
    else pass_cnt++;
    send_bits(32'h1F00_0000, 32, m);
    total_cnt++;
    if (m !== 32'h0200_0000) $display("FAIL b2b_frame_count: got %h want 02000000", m);
    else pass_cnt++;
    cs_release();
    check_drained("back_to_back");
  endtask

  task automatic test_abort();
    logic [31:0] m;
    do_reset();
    cs_assert();
    send_bits(32'h0203_1234, 20, m);
    cs_release();
    total_cnt++;
    if (err !== 3'b001) $display("FAIL abort_error: got %b want 001", err);
    else pass_cnt++;
    cs_assert();
    send_bits(32'h1F00_0000, 32, m);
    total_cnt++;
    if (m !== 32'h0001_0000) $display("FAIL abort_miso: got %h want 00010000", m);
    else pass_cnt++;
    total_cnt++;
    if (err !== 3'b000) $display("FAIL abort_clear: got %b want 000", err);
    else pass_cnt++;
    cs_release();
    check_drained("abort");
  endtask

  task automatic test_rejects();
    logic [31:0] m;
    do_reset();
    cs_assert();
    send_bits(32'h0420_0000, 32, m);
    total_cnt++;
    if (err !== 3'b100) $display("FAIL reject_bad_id: got %b want 100", err);
    else pass_cnt++;
    send_bits(32'h0500_0000, 32, m);
    total_cnt++;
    if (err !== 3'b110) $display("FAIL reject_bad_select: got %b want 110", err);
    else pass_cnt++;
    total_cnt++;
    if ({addr, data} !== 24'h0) $display("FAIL reject_addr_data: got %h %h want 00 0000", addr, data);
    else pass_cnt++;
    send_bits(32'h1F00_0000, 32, m);
    total_cnt++;
    if (m !== 32'h0206_0000) $display("FAIL reject_miso: got %h want 02060000", m);
    else pass_cnt++;
    total_cnt++;
    if (err !== 3'b000) $display("FAIL reject_clear: got %b want 000", err);
    else pass_cnt++;
    cs_release();
    check_drained("rejects");
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] m;
    do_reset();
    cs_assert();
    push_exp(5'b00100, 2'b00, 8'd3, 16'h1234);
    send_bits(32'h0203_1234, 32, m);
    send_bits(32'h0203_1234, 10, m);
    @(negedge clk) rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({env_en, note_en, addr, data, err, miso} !== 34'h0)
      $display("FAIL midreset_outputs: got %h want 0", {env_en, note_en, addr, data, err, miso});
    else
      pass_cnt++;
    cs_n = 1'b1;
    tick(4);
    @(negedge clk) rst_n = 1'b1;
    tick(4);
    cs_assert();
    push_exp(5'b01000, 2'b00, 8'd0, 16'h0ABC);
    send_bits(32'h0300_0ABC, 32, m);
    cs_release();
    total_cnt++;
    if (err !== 3'b000) $display("FAIL midreset_error: got %b want 000", err);
    else pass_cnt++;
    check_drained("reset_mid_frame");
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_envelope();
    test_note_on();
    test_back_to_back();
    test_abort();
    test_rejects();
    test_reset_mid_frame();
    tick(10);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
